// File: rtl/rx_recv_pkg.sv
// rx_recv_pkg: HPSDR host-packet framing constants, receiver states and offset helper
//   Shared by the host-side transmitter and receiver so that both agree on sync bytes,
//   command codes, endpoint, payload length and the USB-frame sync offsets.
package rx_recv_pkg;

    localparam logic [7:0] PKT_TYPE_1    = 8'hEF;
    localparam logic [7:0] PKT_TYPE_2    = 8'hFE;
    localparam logic [7:0] CMD_DATA      = 8'h01;
    localparam logic [7:0] CMD_DISCOVERY = 8'h02;
    localparam logic [7:0] CMD_STARTSTOP = 8'h04;
    localparam logic [7:0] EP_DATA       = 8'h02;

    localparam int         HDR_LEN       = 8;     // EF FE cmd ep + 4 sequence bytes
    localparam int         PAYLOAD_LEN   = 1024;
    localparam int         SEQ_W         = 32;

    localparam int         USB_SYNC_OFS0 = 0;
    localparam int         USB_SYNC_OFS1 = 512;
    localparam int         USB_SYNC_LEN  = 3;
    localparam logic [7:0] USB_SYNC_BYTE = 8'h7F;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC2, ST_CMD, ST_EP, ST_SEQ, ST_DATA, ST_STARTSTOP, ST_SKIP
    } rx_state_e;

    // Payload offset falls on one of the two 3-byte USB-frame sync fields.
    // Written as unsigned distance so offsets below the field start wrap out of range.
    function automatic logic is_sync_ofs(input logic [10:0] ofs);
        return ((ofs - 11'(USB_SYNC_OFS0)) < 11'(USB_SYNC_LEN)) ||
               ((ofs - 11'(USB_SYNC_OFS1)) < 11'(USB_SYNC_LEN));
    endfunction

endpackage

// File: rtl/rx_seq_check.sv
// rx_seq_check: tracks the expected host sequence number and flags out-of-order packets
//   rx_clock, Rx_reset : clock, asynchronous active-high reset
//   load               : a complete 32-bit sequence number is on seq this cycle
//   seq                : received sequence number
//   run                : radio running; while low the history is forgotten
//   seq_error          : one-cycle pulse, cycle after a load that broke the sequence
module rx_seq_check
    import rx_recv_pkg::*;
(
    input  logic             rx_clock,
    input  logic             Rx_reset,
    input  logic             load,
    input  logic [SEQ_W-1:0] seq,
    input  logic             run,
    output logic             seq_error
);

    logic             seq_valid_q;
    logic             err_q;
    logic [SEQ_W-1:0] expected_q;

    always_ff @(posedge rx_clock or posedge Rx_reset) begin
        if (Rx_reset) begin
            seq_valid_q <= 1'b0;
            err_q       <= 1'b0;
            expected_q  <= '0;
        end else begin
            err_q       <= load && seq_valid_q && seq != expected_q;
            expected_q  <= load ? seq + 1'b1 : expected_q;
            // first packet after a start only seeds the expectation
            seq_valid_q <= run && (seq_valid_q || load);
        end
    end

    assign seq_error = err_q;

endmodule

// File: rtl/rx_recv.sv
// rx_recv: HPSDR host-packet receiver; parses EF FE headers and forwards data payload to a FIFO
//   rx_clock, Rx_reset                   : clock, asynchronous active-high reset
//   udp_rx_active/udp_rx_valid/udp_rx_data : UDP payload byte stream, active frames one packet
//   Rx_fifo_full/Rx_fifo_wrreq/Rx_fifo_data : downstream FIFO write port (registered)
//   run, wide_spectrum                   : registered start/stop state
//   discovery, seq_error, sync_error, fifo_overflow : one-cycle pulses
module rx_recv
    import rx_recv_pkg::*;
#(
    parameter logic [7:0] Type_1      = PKT_TYPE_1,
    parameter logic [7:0] Type_2      = PKT_TYPE_2,
    parameter logic [7:0] HPSDR_frame = CMD_DATA,
    parameter logic [7:0] DATA_EP     = EP_DATA
) (
    input  logic       rx_clock,
    input  logic       Rx_reset,
    input  logic       udp_rx_active,
    input  logic       udp_rx_valid,
    input  logic [7:0] udp_rx_data,
    input  logic       Rx_fifo_full,
    output logic       Rx_fifo_wrreq,
    output logic [7:0] Rx_fifo_data,
    output logic       run,
    output logic       wide_spectrum,
    output logic       discovery,
    output logic       seq_error,
    output logic       sync_error,
    output logic       fifo_overflow
);

    rx_state_e   state_q, state_d;
    logic [10:0] byte_no_q;
    logic        armed_q;
    logic [23:0] seq_hi_q;
    logic        wrreq_q, run_q, wide_q, disc_q, sync_err_q, ovf_q;
    logic [7:0]  data_q;
    logic        take, in_data, seq_load;
    logic [10:0] ofs;

    assign take     = udp_rx_active && udp_rx_valid;
    assign in_data  = take && state_q == ST_DATA;
    assign ofs      = byte_no_q - 11'(HDR_LEN);
    // sequence bytes sit at byte_no 4..7, so the last one has byte_no[1:0] == 3
    assign seq_load = take && state_q == ST_SEQ && byte_no_q[1:0] == 2'd3;

    always_comb begin
        state_d = state_q;
        if (!udp_rx_active) begin
            state_d = ST_IDLE;
        end else if (udp_rx_valid) begin
            case (state_q)
                // armed_q is only set once active has been seen low, so a packet
                // already in flight when reset released is never parsed
                ST_IDLE:  state_d = (armed_q && udp_rx_data == Type_1) ? ST_SYNC2 : ST_SKIP;
                ST_SYNC2: state_d = udp_rx_data == Type_2 ? ST_CMD : ST_SKIP;
                ST_CMD:   state_d = udp_rx_data == HPSDR_frame   ? ST_EP :
                                    udp_rx_data == CMD_STARTSTOP ? ST_STARTSTOP : ST_SKIP;
                ST_EP:    state_d = udp_rx_data == DATA_EP ? ST_SEQ : ST_SKIP;
                ST_SEQ:   state_d = byte_no_q[1:0] == 2'd3 ? ST_DATA : ST_SEQ;
                ST_DATA:  state_d = ofs == 11'(PAYLOAD_LEN - 1) ? ST_SKIP : ST_DATA;
                default:  state_d = ST_SKIP;
            endcase
        end
    end

    always_ff @(posedge rx_clock or posedge Rx_reset) begin
        if (Rx_reset) begin
            state_q    <= ST_IDLE;
            byte_no_q  <= '0;
            armed_q    <= 1'b0;
            seq_hi_q   <= '0;
            wrreq_q    <= 1'b0;
            data_q     <= '0;
            run_q      <= 1'b0;
            wide_q     <= 1'b0;
            disc_q     <= 1'b0;
            sync_err_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_no_q  <= !udp_rx_active ? '0 : byte_no_q + 11'(udp_rx_valid);
            armed_q    <= armed_q || !udp_rx_active;
            seq_hi_q   <= (take && state_q == ST_SEQ) ? {seq_hi_q[15:0], udp_rx_data} : seq_hi_q;
            wrreq_q    <= in_data && !Rx_fifo_full;
            data_q     <= in_data ? udp_rx_data : data_q;
            ovf_q      <= in_data && Rx_fifo_full;
            sync_err_q <= in_data && is_sync_ofs(ofs) && udp_rx_data != USB_SYNC_BYTE;
            disc_q     <= take && state_q == ST_CMD && udp_rx_data == CMD_DISCOVERY;
            if (take && state_q == ST_STARTSTOP) {wide_q, run_q} <= udp_rx_data[1:0];
        end
    end

    rx_seq_check u_seq_check (
        .rx_clock  (rx_clock),
        .Rx_reset  (Rx_reset),
        .load      (seq_load),
        .seq       ({seq_hi_q, udp_rx_data}),
        .run       (run_q),
        .seq_error (seq_error)
    );

    assign Rx_fifo_wrreq = wrreq_q;
    assign Rx_fifo_data  = data_q;
    assign run           = run_q;
    assign wide_spectrum = wide_q;
    assign discovery     = disc_q;
    assign sync_error    = sync_err_q;
    assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_rx_recv.sv
// tb_rx_recv: randomized packet-level bench for rx_recv with a behavioural packet model
module tb_rx_recv;
    import rx_recv_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic       wr;
        logic [7:0] d;
        logic       ovf, syn, disc, serr, run, wide;
    } exp_t;

    logic       rx_clock = 1'b0;
    logic       Rx_reset = 1'b1;
    logic       udp_rx_active = 1'b0;
    logic       udp_rx_valid = 1'b0;
    logic [7:0] udp_rx_data = 8'h00;
    logic       Rx_fifo_full = 1'b0;
    logic       Rx_fifo_wrreq, run, wide_spectrum, discovery, seq_error, sync_error, fifo_overflow;
    logic [7:0] Rx_fifo_data;

    always #5 rx_clock = ~rx_clock;

    rx_recv dut (
        .rx_clock      (rx_clock),
        .Rx_reset      (Rx_reset),
        .udp_rx_active (udp_rx_active),
        .udp_rx_valid  (udp_rx_valid),
        .udp_rx_data   (udp_rx_data),
        .Rx_fifo_full  (Rx_fifo_full),
        .Rx_fifo_wrreq (Rx_fifo_wrreq),
        .Rx_fifo_data  (Rx_fifo_data),
        .run           (run),
        .wide_spectrum (wide_spectrum),
        .discovery     (discovery),
        .seq_error     (seq_error),
        .sync_error    (sync_error),
        .fifo_overflow (fifo_overflow)
    );

    exp_t        exq[$];
    int          total = 0, bad = 0;
    int          c_wr = 0, c_ovf = 0, c_syn = 0, c_disc = 0, c_serr = 0;
    logic        m_run = 1'b0, m_wide = 1'b0, m_valid = 1'b0;
    logic [31:0] m_exp = 32'h0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endfunction

    // one expectation per driven cycle, checked #1 after the edge that registers it
    always @(posedge rx_clock) begin : cmp
        exp_t e;
        #1;
        if (exq.size() > 0) begin
            e = exq.pop_front();
            c_wr   += int'(Rx_fifo_wrreq);
            c_ovf  += int'(fifo_overflow);
            c_syn  += int'(sync_error);
            c_disc += int'(discovery);
            c_serr += int'(seq_error);
            chk("wrreq", 32'(Rx_fifo_wrreq), 32'(e.wr));
            if (e.wr) chk("wdata", 32'(Rx_fifo_data), 32'(e.d));
            chk("fifo_overflow", 32'(fifo_overflow), 32'(e.ovf));
            chk("sync_error", 32'(sync_error), 32'(e.syn));
            chk("discovery", 32'(discovery), 32'(e.disc));
            chk("seq_error", 32'(seq_error), 32'(e.serr));
            chk("run", 32'(run), 32'(e.run));
            chk("wide_spectrum", 32'(wide_spectrum), 32'(e.wide));
        end
    end

    function automatic exp_t quiet();
        exp_t e = '0;
        e.run  = m_run;
        e.wide = m_wide;
        return e;
    endfunction

    task automatic cyc(input logic act, input logic vld, input logic [7:0] d, input logic full, input exp_t e);
        @(negedge rx_clock);
        udp_rx_active = act;
        udp_rx_valid  = vld;
        udp_rx_data   = d;
        Rx_fifo_full  = full;
        exq.push_back(e);
    endtask

    // Drives len bytes of b with random gaps. The model decodes the packet by byte
    // position: header at 0..3, sequence at 4..7, payload at 8..1031.
    // FIFO is full for payload offsets flo..fhi. match=0 means the packet must be ignored.
    task automatic send(input bq_t b, input int len, input int flo, input int fhi, input bit match, input bit tail);
        bit          hdr, dat;
        exp_t        e;
        int          o;
        logic        full;
        logic [7:0]  v;
        logic [31:0] s;
        hdr = match && len >= 3 && b[0] == 8'hEF && b[1] == 8'hFE;
        dat = hdr && len >= 4 && b[2] == 8'h01 && b[3] == 8'h02;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(3) == 0) cyc(1'b1, 1'b0, 8'($urandom), 1'($urandom), quiet());
            e    = quiet();
            o    = i - 8;
            full = 1'b0;
            if (dat && o >= 0 && o < 1024) begin
                full  = o >= flo && o <= fhi;
                e.wr  = !full;
                e.d   = b[i];
                e.ovf = full;
                e.syn = (o < 3 || (o >= 512 && o < 515)) && b[i] != 8'h7F;
            end
            if (hdr && i == 2 && b[2] == 8'h02) e.disc = 1'b1;
            if (hdr && i == 3 && b[2] == 8'h04) begin
                v      = b[3];
                m_run  = v[0];
                m_wide = v[1];
                if (!m_run) m_valid = 1'b0;
                e.run  = m_run;
                e.wide = m_wide;
            end
            if (dat && i == 7) begin
                s       = {b[4], b[5], b[6], b[7]};
                e.serr  = m_valid && s != m_exp;
                m_exp   = s + 32'd1;
                m_valid = m_run;
            end
            cyc(1'b1, 1'b1, b[i], full, e);
        end
        if (tail) repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0, quiet());
        @(posedge rx_clock);
        #2;
    endtask

    function automatic bq_t mk_data(input logic [7:0] ep, input logic [31:0] s, input bit bad_sync);
        bq_t b;
        b.push_back(8'hEF); b.push_back(8'hFE); b.push_back(8'h01); b.push_back(ep);
        for (int k = 3; k >= 0; k--) b.push_back(s[8*k +: 8]);
        for (int o = 0; o < 1024; o++)
            b.push_back((o < 3 || (o >= 512 && o < 515)) ?
                        ((bad_sync && (o == 1 || o == 513)) ? 8'h3C : 8'h7F) : 8'($urandom));
        return b;
    endfunction

    function automatic bq_t mk_cmd(input logic [7:0] cmd, input int pad);
        bq_t b;
        b.push_back(8'hEF); b.push_back(8'hFE); b.push_back(cmd);
        for (int k = 0; k < pad; k++) b.push_back(8'($urandom));
        return b;
    endfunction

    function automatic bq_t mk_ss(input logic [1:0] bits);
        bq_t b = mk_cmd(8'h04, 0);
        b.push_back({6'($urandom), bits});
        for (int k = 0; k < 4; k++) b.push_back(8'($urandom));
        return b;
    endfunction

    function automatic void clr();
        c_wr = 0; c_ovf = 0; c_syn = 0; c_disc = 0; c_serr = 0;
    endfunction

    task automatic check_zero(string tag);
        chk({tag, "_wrreq"}, 32'(Rx_fifo_wrreq), 32'd0);
        chk({tag, "_wdata"}, 32'(Rx_fifo_data), 32'd0);
        chk({tag, "_run"}, 32'(run), 32'd0);
        chk({tag, "_wide"}, 32'(wide_spectrum), 32'd0);
        chk({tag, "_disc"}, 32'(discovery), 32'd0);
        chk({tag, "_pulses"}, 32'({seq_error, sync_error, fifo_overflow}), 32'd0);
    endtask

    initial begin : main
        bq_t b;
        int  lo, k;
        repeat (2) @(negedge rx_clock);
        check_zero("reset");
        Rx_reset = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0, quiet());

        // plain data packet, radio stopped
        clr(); b = mk_data(8'h02, 32'd0, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        chk("data_wr_count", 32'(c_wr), 32'd1024);
        chk("data_err_count", 32'(c_syn + c_ovf + c_serr + c_disc), 32'd0);

        // start with wide spectrum
        send(mk_ss(2'b11), 9, 2000, 0, 1'b1, 1'b1);
        chk("start_run", 32'(run), 32'd1);
        chk("start_wide", 32'(wide_spectrum), 32'd1);

        // sequence 5, 7 (gap), 8, FFFFFFFF, 0 (wrap)
        b = mk_data(8'h02, 32'd5, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        clr(); b = mk_data(8'h02, 32'd7, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        chk("seq_gap_errors", 32'(c_serr), 32'd1);
        clr(); b = mk_data(8'h02, 32'd8, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        chk("seq_next_errors", 32'(c_serr), 32'd0);
        b = mk_data(8'h02, 32'hFFFF_FFFF, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        clr(); b = mk_data(8'h02, 32'd0, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        chk("seq_wrap_errors", 32'(c_serr), 32'd0);

        // discovery with padding
        clr(); b = mk_cmd(8'h02, 60); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        chk("disc_pulses", 32'(c_disc), 32'd1);
        chk("disc_wr_count", 32'(c_wr), 32'd0);

        // FIFO full on payload bytes 100..103
        clr(); b = mk_data(8'h02, 32'd1, 1'b0); send(b, b.size(), 100, 103, 1'b1, 1'b1);
        chk("full_wr_count", 32'(c_wr), 32'd1020);
        chk("full_ovf_count", 32'(c_ovf), 32'd4);

        // wrong endpoint
        clr(); b = mk_data(8'h04, 32'd2, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        chk("bad_ep_wr_count", 32'(c_wr), 32'd0);

        // corrupted sync bytes at offsets 1 and 513
        clr(); b = mk_data(8'h02, 32'd2, 1'b1); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        chk("sync_err_count", 32'(c_syn), 32'd2);
        chk("sync_wr_count", 32'(c_wr), 32'd1024);

        // stop: history cleared, so an out-of-order pair raises nothing
        send(mk_ss(2'b00), 9, 2000, 0, 1'b1, 1'b1);
        chk("stop_run", 32'(run), 32'd0);
        chk("stop_wide", 32'(wide_spectrum), 32'd0);
        clr();
        b = mk_data(8'h02, 32'd100, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        b = mk_data(8'h02, 32'd50, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        chk("stopped_seq_errors", 32'(c_serr), 32'd0);

        // truncated after 300 payload bytes
        clr(); b = mk_data(8'h02, 32'd3, 1'b0); send(b, 308, 2000, 0, 1'b1, 1'b1);
        chk("trunc_wr_count", 32'(c_wr), 32'd300);

        // reset mid-packet, then the rest of a well-formed packet must be ignored
        send(mk_ss(2'b01), 9, 2000, 0, 1'b1, 1'b1);
        b = mk_data(8'h02, 32'd9, 1'b0); send(b, 5, 2000, 0, 1'b1, 1'b0);
        @(negedge rx_clock);
        Rx_reset = 1'b1;
        #1;
        check_zero("midreset");
        m_run = 1'b0; m_wide = 1'b0; m_valid = 1'b0; m_exp = 32'h0;
        @(negedge rx_clock);
        @(negedge rx_clock);
        Rx_reset = 1'b0;
        clr(); send(b, b.size(), 2000, 0, 1'b0, 1'b1);
        chk("post_reset_skip_wr", 32'(c_wr), 32'd0);
        clr(); b = mk_data(8'h02, 32'd10, 1'b0); send(b, b.size(), 2000, 0, 1'b1, 1'b1);
        chk("post_reset_wr_count", 32'(c_wr), 32'd1024);

        // randomized mix of packet kinds
        for (int n = 0; n < 8; n++) begin
            k = int'($urandom_range(4));
            lo = int'($urandom_range(1023));
            case (k)
                0: begin
                    b = mk_data(($urandom_range(4) == 0) ? 8'h03 : 8'h02,
                                ($urandom_range(1) == 1) ? m_exp : $urandom, 1'($urandom_range(1)));
                    send(b, b.size(), lo, lo + int'($urandom_range(5)), 1'b1, 1'b1);
                end
                1: begin b = mk_cmd(8'h02, int'($urandom_range(0, 60))); send(b, b.size(), 2000, 0, 1'b1, 1'b1); end
                2: send(mk_ss(2'($urandom)), 9, 2000, 0, 1'b1, 1'b1);
                3: begin
                    b = mk_cmd(8'($urandom), 20);
                    if ($urandom_range(1) == 1) b[0] = 8'($urandom);
                    send(b, b.size(), 2000, 0, 1'b1, 1'b1);
                end
                default: begin
                    b = mk_data(8'h02, m_exp, 1'b0);
                    send(b, int'($urandom_range(2, 100)), 0, 1023, 1'b1, 1'b1);
                end
            endcase
        end

        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0, quiet());
        @(posedge rx_clock);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
